// File: rtl/mtsp_mem_responder_if.sv
// Meitner master bus, memory side: request, write-beat,
// read-beat and write-response channels.
interface mtsp_mem_responder_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  REQ_VALID;
    logic                  REQ_READY;
    logic                  REQ_WRITE;
    logic [ADDR_WIDTH-1:0] REQ_ADDR;
    logic [7:0]            REQ_LEN;
    logic                  WVALID;
    logic                  WREADY;
    logic [255:0]          WDATA;
    logic                  RVALID;
    logic                  RREADY;
    logic [255:0]          RDATA;
    logic                  RLAST;
    logic                  BVALID;
    logic                  BREADY;
    logic                  BUSY;

    modport master (
        output REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_LEN,
        output WVALID, WDATA, RREADY, BREADY,
        input  REQ_READY, WREADY, RVALID, RDATA, RLAST,
        input  BVALID, BUSY
    );

    modport slave (
        input  REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_LEN,
        input  WVALID, WDATA, RREADY, BREADY,
        output REQ_READY, WREADY, RVALID, RDATA, RLAST,
        output BVALID, BUSY
    );
endinterface

// File: rtl/mtsp_mem_responder.sv
// Meitner bus memory responder: line-wide SRAM target for
// 256-bit burst reads/writes with programmable read latency.
module mtsp_mem_responder #(
    parameter int ADDR_WIDTH     = 32,
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int READ_LATENCY   = 2
) (
    input  logic CLK,
    input  logic nRST,
    mtsp_mem_responder_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_WRESP = 3'd2;
    localparam logic [2:0] S_RWAIT = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;

    localparam int         DEPTH = 1 << MEM_DEPTH_LOG2;
    localparam logic [3:0] LAT   = 4'(READ_LATENCY);

    logic [2:0]                state;
    logic                      up;
    logic [MEM_DEPTH_LOG2-1:0] idx;
    logic [MEM_DEPTH_LOG2-1:0] idx_nxt;
    logic [MEM_DEPTH_LOG2-1:0] req_idx;
    logic [7:0]                cnt;
    logic [3:0]                lat_cnt;
    logic [255:0]              rdata;
    logic [255:0]              mem [DEPTH];

    logic st_idle, st_write, st_wresp, st_rwait, st_read;
    logic req_hs, w_hs, r_hs;
    logic [ADDR_WIDTH-1:0]     unused_addr;

    assign unused_addr = bus.REQ_ADDR;
    assign req_idx = bus.REQ_ADDR[MEM_DEPTH_LOG2+4:5];
    assign idx_nxt = idx + MEM_DEPTH_LOG2'(1);

    assign st_idle  = (state == S_IDLE);
    assign st_write = (state == S_WRITE);
    assign st_wresp = (state == S_WRESP);
    assign st_rwait = (state == S_RWAIT);
    assign st_read  = (state == S_READ);

    // REQ_READY is held off until the first clock after reset release
    assign bus.REQ_READY = up & st_idle;
    assign bus.WREADY    = st_write;
    assign bus.BVALID    = st_wresp;
    assign bus.RVALID    = st_read;
    assign bus.RLAST     = st_read & (cnt == 8'd0);
    assign bus.RDATA     = rdata;
    assign bus.BUSY      = ~st_idle;

    assign req_hs = bus.REQ_VALID & bus.REQ_READY;
    assign w_hs   = bus.WVALID & st_write;
    assign r_hs   = bus.RREADY & st_read;

    always_ff @(posedge CLK) begin
        if (w_hs) mem[idx] <= bus.WDATA;
    end

    // rdata always holds the current beat; next line is fetched on handshake
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= S_IDLE;
            up      <= 1'b0;
            idx     <= '0;
            cnt     <= '0;
            lat_cnt <= '0;
            rdata   <= '0;
        end else begin
            up <= 1'b1;
            unique case (1'b1)
                st_idle: begin
                    if (req_hs) begin
                        idx     <= req_idx;
                        cnt     <= bus.REQ_LEN;
                        lat_cnt <= LAT - 4'd1;
                        if (bus.REQ_WRITE) begin
                            state <= S_WRITE;
                        end else begin
                            rdata <= mem[req_idx];
                            if (LAT == 4'd0) state <= S_READ;
                            else             state <= S_RWAIT;
                        end
                    end
                end
                st_write: begin
                    if (w_hs) begin
                        idx <= idx_nxt;
                        cnt <= cnt - 8'd1;
                        if (cnt == 8'd0) state <= S_WRESP;
                    end
                end
                st_wresp: begin
                    if (bus.BREADY) state <= S_IDLE;
                end
                st_rwait: begin
                    if (lat_cnt == 4'd0) state <= S_READ;
                    else                 lat_cnt <= lat_cnt - 4'd1;
                end
                st_read: begin
                    if (r_hs) begin
                        if (cnt == 8'd0) begin
                            state <= S_IDLE;
                        end else begin
                            cnt   <= cnt - 8'd1;
                            idx   <= idx_nxt;
                            rdata <= mem[idx_nxt];
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mtsp_mem_responder.sv
// Scoreboard bench for mtsp_mem_responder: directed bursts,
// latency, backpressure, wrap/alias, single beat, mid-burst reset.
module tb_mtsp_mem_responder;
    typedef struct {
        logic [255:0] data;
        logic         last;
    } beat_t;

    logic clk;
    logic nrst;
    int   cyc;
    int   total;
    int   bad;
    int   bq;
    beat_t rq[$];
    int   beat_cyc[$];

    mtsp_mem_responder_if #(.ADDR_WIDTH(32)) bus ();

    mtsp_mem_responder dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [255:0] rep(input logic [7:0] b);
        return {32{b}};
    endfunction

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    // Monitor: compare every presented read beat, pop on handshake
    always @(negedge clk) begin
        if (nrst && bus.RVALID) begin
            if (rq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rvalid_unexpected: got 1 want 0");
            end else begin
                chk("rdata", bus.RDATA, rq[0].data);
                chk("rlast", 256'(bus.RLAST), 256'(rq[0].last));
                if (bus.RREADY) begin
                    void'(rq.pop_front());
                    beat_cyc.push_back(cyc);
                end
            end
        end
        if (nrst && bus.BVALID && bus.BREADY) begin
            if (bq == 0) begin
                total++;
                bad++;
                $display("FAIL bresp_unexpected: got 1 want 0");
            end else begin
                bq--;
            end
        end
    end

    task automatic do_req(input logic wr, input logic [31:0] addr,
                          input logic [7:0] len, output int t);
        bus.REQ_VALID = 1'b1;
        bus.REQ_WRITE = wr;
        bus.REQ_ADDR  = addr;
        bus.REQ_LEN   = len;
        t = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.REQ_READY) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) timeout("req_ready");
        @(posedge clk);
        #1;
        bus.REQ_VALID = 1'b0;
    endtask

    task automatic wr_beats(input logic [7:0] base, input logic [7:0] step,
                            input int n, input int gap);
        bit ok;
        for (int k = 0; k < n; k++) begin
            if (k == gap) begin
                bus.WVALID = 1'b0;
                repeat (2) @(posedge clk);
                #1;
            end
            bus.WVALID = 1'b1;
            bus.WDATA  = rep(base + 8'(k) * step);
            ok = 0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (bus.WREADY) begin
                    ok = 1;
                    break;
                end
            end
            if (!ok) timeout("wready");
            @(posedge clk);
            #1;
        end
        bus.WVALID = 1'b0;
    endtask

    task automatic b_resp(input int hold);
        bq++;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bvalid_hold", 256'(bus.BVALID), 256'(1));
            @(posedge clk);
            #1;
        end
        bus.BREADY = 1'b1;
        @(negedge clk);
        chk("bvalid", 256'(bus.BVALID), 256'(1));
        @(posedge clk);
        #1;
        bus.BREADY = 1'b0;
        @(negedge clk);
        chk("bvalid_drop", 256'(bus.BVALID), 256'(0));
        chk("busy_after_b", 256'(bus.BUSY), 256'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic write_burst(input logic [31:0] addr, input logic [7:0] len,
                               input logic [7:0] base, input logic [7:0] step,
                               input int gap, input int hold);
        int t;
        do_req(1'b1, addr, len, t);
        wr_beats(base, step, int'(len) + 1, gap);
        b_resp(hold);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [7:0] len,
                      input logic [7:0] base, input logic [7:0] step,
                      input bit bp, output int t);
        bit done;
        logic [3:0] pat;
        beat_t b;
        pat = 4'b1001;
        for (int k = 0; k <= int'(len); k++) begin
            b.data = rep(base + 8'(k) * step);
            b.last = (k == int'(len));
            rq.push_back(b);
        end
        beat_cyc.delete();
        bus.RREADY = ~bp;
        do_req(1'b0, addr, len, t);
        done = 0;
        for (int i = 0; i < 200; i++) begin
            if (bp) bus.RREADY = pat[3 - ((i + 2) % 4)];
            @(posedge clk);
            if (rq.size() == 0) begin
                done = 1;
                break;
            end
            #1;
        end
        if (!done) begin
            timeout("read_done");
            rq.delete();
        end
        #1;
        bus.RREADY = 1'b0;
    endtask

    task automatic chk_outs_zero(input string nm);
        chk({nm, "_req_ready"}, 256'(bus.REQ_READY), 256'(0));
        chk({nm, "_wready"}, 256'(bus.WREADY), 256'(0));
        chk({nm, "_rvalid"}, 256'(bus.RVALID), 256'(0));
        chk({nm, "_rlast"}, 256'(bus.RLAST), 256'(0));
        chk({nm, "_bvalid"}, 256'(bus.BVALID), 256'(0));
        chk({nm, "_busy"}, 256'(bus.BUSY), 256'(0));
        chk({nm, "_rdata"}, bus.RDATA, 256'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        total = 0;
        bad   = 0;
        bq    = 0;
        bus.REQ_VALID = 1'b0;
        bus.REQ_WRITE = 1'b0;
        bus.REQ_ADDR  = '0;
        bus.REQ_LEN   = '0;
        bus.WVALID    = 1'b0;
        bus.WDATA     = '0;
        bus.RREADY    = 1'b0;
        bus.BREADY    = 1'b0;
        nrst = 1'b1;
        #2;
        nrst = 1'b0;
        #1;
        chk_outs_zero("reset");
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        #1;
        chk("req_ready_release", 256'(bus.REQ_READY), 256'(0));
        @(negedge clk);
        chk("req_ready_up", 256'(bus.REQ_READY), 256'(1));
        chk("busy_idle", 256'(bus.BUSY), 256'(0));
        bus.REQ_VALID = 1'b1;
        #1;
        chk("busy_idle_reqv", 256'(bus.BUSY), 256'(0));
        bus.REQ_VALID = 1'b0;
        @(posedge clk);
        #1;

        write_burst(32'h100, 8'd3, 8'hA0, 8'h01, 2, 0);
        rd(32'h100, 8'd3, 8'hA0, 8'h01, 1'b0, t);
        chk("beat_count", 256'(beat_cyc.size()), 256'(4));
        for (int j = 0; j < 4; j++) begin
            if (j < beat_cyc.size())
                chk($sformatf("beat%0d_cycle", j),
                    256'(beat_cyc[j]), 256'(t + 3 + j));
        end

        rd(32'h100, 8'd3, 8'hA0, 8'h01, 1'b1, t);
        chk("bp_beat_count", 256'(beat_cyc.size()), 256'(4));

        write_burst(32'h7FE0, 8'd1, 8'h11, 8'h11, -1, 0);
        rd(32'h7FE0, 8'd0, 8'h11, 8'h00, 1'b0, t);
        rd(32'h0000, 8'd0, 8'h22, 8'h00, 1'b0, t);
        rd(32'h8000, 8'd0, 8'h22, 8'h00, 1'b0, t);
        rd(32'h7FE0, 8'd1, 8'h11, 8'h11, 1'b0, t);

        write_burst(32'h200, 8'd0, 8'h5A, 8'h00, -1, 5);
        rd(32'h200, 8'd0, 8'h5A, 8'h00, 1'b0, t);
        @(negedge clk);
        chk("busy_after_rlast", 256'(bus.BUSY), 256'(0));
        chk("req_ready_after_rlast", 256'(bus.REQ_READY), 256'(1));
        @(posedge clk);
        #1;

        do_req(1'b1, 32'h0, 8'd3, t);
        wr_beats(8'hC0, 8'h01, 2, -1);
        @(negedge clk);
        chk("mid_wready", 256'(bus.WREADY), 256'(1));
        #2;
        nrst = 1'b0;
        #1;
        chk_outs_zero("mid_reset");
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        chk("req_ready_after_abort", 256'(bus.REQ_READY), 256'(1));
        @(posedge clk);
        #1;
        rd(32'h0, 8'd1, 8'hC0, 8'h01, 1'b0, t);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 256'(rq.size() + bq), 256'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
